// File: rtl/mel_log_compress.sv
// rtl/mel_log_compress.sv - fixed-point log2 of mel energies, band-tagged, buffered in an output FIFO
// Optional MEL_LOG_LUT_EN adds a 16-entry log2(1+f) correction ROM in S3 (table scaled for FRAC_BITS=8).
module mel_log_compress #(
  parameter int WIDTH      = 16,
  parameter int N_MEL      = 40,
  parameter int FRAC_BITS  = 8,
  parameter int OUT_W      = 16,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          mel_spec_vld,
  input  logic [WIDTH-1:0]              mel_spec,
  input  logic                          frame_rst,
  input  logic                          clear_ovf,
  output logic                          out_vld,
  input  logic                          out_rdy,
  output logic [OUT_W-1:0]              out_data,
  output logic [7:0]                    out_idx,
  output logic                          out_last,
  output logic                          overflow,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int INT_W = $clog2(WIDTH);
  localparam int RES_W = INT_W + FRAC_BITS;
  localparam int FR_W  = WIDTH - 1;
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = PTR_W + 1;

  logic [7:0]             band_q, band_d, tag;
  logic                   s1_vld_q, s1_vld_d;
  logic [WIDTH-1:0]       s1_data_q, s1_data_d;
  logic [7:0]             s1_idx_q, s1_idx_d;
  logic                   s2_vld_q, s2_vld_d;
  logic [INT_W-1:0]       s2_pos_q, s2_pos_d;
  logic [FRAC_BITS-1:0]   s2_frac_q, s2_frac_d;
  logic [7:0]             s2_idx_q, s2_idx_d;
  logic                   s3_vld_q, s3_vld_d;
  logic [RES_W-1:0]       s3_res_q, s3_res_d;
  logic [7:0]             s3_idx_q, s3_idx_d;
  logic                   s3_last_q, s3_last_d;

  logic [RES_W-1:0]       mem_res_q  [FIFO_DEPTH];
  logic [7:0]             mem_idx_q  [FIFO_DEPTH];
  logic                   mem_last_q [FIFO_DEPTH];
  logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, rd_next;
  logic [LVL_W-1:0]       level_q, level_d;
  logic                   out_vld_q, out_vld_d, out_last_q, out_last_d, ovf_q, ovf_d;
  logic [OUT_W-1:0]       out_data_q, out_data_d;
  logic [7:0]             out_idx_q, out_idx_d;

  logic [INT_W-1:0]       pos, shamt;
  logic [WIDTH-1:0]       norm;
  logic [RES_W-1:0]       lin;
  logic                   pop, push, full, drop;

  // Band counter: frame_rst wins and tags the coincident sample as band 0.
  always_comb begin
    tag    = frame_rst ? 8'd0 : band_q;
    band_d = band_q;
    if (frame_rst)
      band_d = (mel_spec_vld && N_MEL > 1) ? 8'd1 : 8'd0;
    else if (mel_spec_vld)
      band_d = (band_q == 8'(N_MEL - 1)) ? 8'd0 : band_q + 8'd1;
    s1_vld_d  = mel_spec_vld;
    s1_data_d = mel_spec_vld ? mel_spec : s1_data_q;
    s1_idx_d  = mel_spec_vld ? tag : s1_idx_q;
  end

  // S2: leading-one position, then shift so the bits below it become the fraction.
  always_comb begin
    pos = '0;
    for (int i = 0; i < WIDTH; i++)
      if (s1_data_q[i]) pos = INT_W'(i);
    shamt     = INT_W'(FR_W) - pos;
    norm      = s1_data_q << shamt;
    s2_vld_d  = s1_vld_q;
    s2_pos_d  = pos;
    s2_frac_d = FRAC_BITS'(norm >> (FR_W - FRAC_BITS));
    s2_idx_d  = s1_idx_q;
  end

`ifdef MEL_LOG_LUT_EN
  logic [7:0]       corr;
  logic [RES_W:0]   sum;
  always_comb begin
    case (s2_frac_q[FRAC_BITS-1 -: 4])
      4'd0:  corr = 8'd0;   4'd1:  corr = 8'd6;   4'd2:  corr = 8'd12;  4'd3:  corr = 8'd15;
      4'd4:  corr = 8'd18;  4'd5:  corr = 8'd20;  4'd6:  corr = 8'd22;  4'd7:  corr = 8'd22;
      4'd8:  corr = 8'd22;  4'd9:  corr = 8'd21;  4'd10: corr = 8'd19;  4'd11: corr = 8'd17;
      4'd12: corr = 8'd15;  4'd13: corr = 8'd12;  4'd14: corr = 8'd8;   default: corr = 8'd4;
    endcase
    lin      = {s2_pos_q, s2_frac_q};
    sum      = {1'b0, lin} + (RES_W + 1)'(corr);
    s3_res_d = sum[RES_W] ? '1 : sum[RES_W-1:0];
  end
`else
  always_comb begin
    lin      = {s2_pos_q, s2_frac_q};
    s3_res_d = lin;
  end
`endif

  always_comb begin
    s3_vld_d  = s2_vld_q;
    s3_idx_d  = s2_idx_q;
    s3_last_d = (s2_idx_q == 8'(N_MEL - 1));
  end

  // FIFO: out_* registers always mirror the entry at rd_ptr; memory slot is reused once popped.
  always_comb begin
    pop      = out_vld_q & out_rdy;
    full     = (level_q == LVL_W'(FIFO_DEPTH));
    push     = s3_vld_q & (~full | pop);
    drop     = s3_vld_q & full & ~pop;
    rd_next  = rd_ptr_q + 1'b1;
    wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop ? rd_next : rd_ptr_q;
    level_d  = level_q + LVL_W'(push) - LVL_W'(pop);
    ovf_d    = drop ? 1'b1 : (clear_ovf ? 1'b0 : ovf_q);
    out_vld_d  = out_vld_q;
    out_data_d = out_data_q;
    out_idx_d  = out_idx_q;
    out_last_d = out_last_q;
    if (pop && level_q > LVL_W'(1)) begin
      out_data_d = OUT_W'(mem_res_q[rd_next]);
      out_idx_d  = mem_idx_q[rd_next];
      out_last_d = mem_last_q[rd_next];
    end else if (push && (pop || !out_vld_q)) begin
      out_vld_d  = 1'b1;
      out_data_d = OUT_W'(s3_res_q);
      out_idx_d  = s3_idx_q;
      out_last_d = s3_last_q;
    end else if (pop) begin
      out_vld_d  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_res_q[wr_ptr_q]  <= s3_res_q;
      mem_idx_q[wr_ptr_q]  <= s3_idx_q;
      mem_last_q[wr_ptr_q] <= s3_last_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      band_q <= '0; s1_vld_q <= 1'b0; s2_vld_q <= 1'b0; s3_vld_q <= 1'b0;
      s1_data_q <= '0; s1_idx_q <= '0; s2_pos_q <= '0; s2_frac_q <= '0; s2_idx_q <= '0;
      s3_res_q <= '0; s3_idx_q <= '0; s3_last_q <= 1'b0;
      wr_ptr_q <= '0; rd_ptr_q <= '0; level_q <= '0; ovf_q <= 1'b0;
      out_vld_q <= 1'b0; out_data_q <= '0; out_idx_q <= '0; out_last_q <= 1'b0;
    end else begin
      band_q <= band_d; s1_vld_q <= s1_vld_d; s2_vld_q <= s2_vld_d; s3_vld_q <= s3_vld_d;
      s1_data_q <= s1_data_d; s1_idx_q <= s1_idx_d;
      s2_pos_q <= s2_pos_d; s2_frac_q <= s2_frac_d; s2_idx_q <= s2_idx_d;
      s3_res_q <= s3_res_d; s3_idx_q <= s3_idx_d; s3_last_q <= s3_last_d;
      wr_ptr_q <= wr_ptr_d; rd_ptr_q <= rd_ptr_d; level_q <= level_d; ovf_q <= ovf_d;
      out_vld_q <= out_vld_d; out_data_q <= out_data_d; out_idx_q <= out_idx_d; out_last_q <= out_last_d;
    end
  end

  assign out_vld    = out_vld_q;
  assign out_data   = out_data_q;
  assign out_idx    = out_idx_q;
  assign out_last   = out_last_q;
  assign overflow   = ovf_q;
  assign fifo_level = level_q;

endmodule

// File: tb/tb_mel_log_compress.sv
// tb/tb_mel_log_compress.sv - directed self-checking bench for mel_log_compress
module tb_mel_log_compress;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mel_spec_vld = 1'b0;
  logic [15:0] mel_spec = '0;
  logic        frame_rst = 1'b0;
  logic        clear_ovf = 1'b0;
  logic        out_vld;
  logic        out_rdy = 1'b0;
  logic [15:0] out_data;
  logic [7:0]  out_idx;
  logic        out_last;
  logic        overflow;
  logic [3:0]  fifo_level;

  int n_chk = 0;
  int n_fail = 0;

  bit          st_vld[$], st_frst[$];
  logic [15:0] st_data[$];
  int          exp_data[$], exp_idx[$];
  int          got_data[$], got_idx[$], got_last[$];

  mel_log_compress dut (
    .clk(clk), .rst(rst), .mel_spec_vld(mel_spec_vld), .mel_spec(mel_spec),
    .frame_rst(frame_rst), .clear_ovf(clear_ovf), .out_vld(out_vld), .out_rdy(out_rdy),
    .out_data(out_data), .out_idx(out_idx), .out_last(out_last), .overflow(overflow),
    .fifo_level(fifo_level)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic single(input logic [15:0] d, input logic [15:0] e, input int idx);
    out_rdy = 1'b1; mel_spec = d; mel_spec_vld = 1'b1;
    step();
    mel_spec_vld = 1'b0;
    for (int k = 1; k < 4; k++) begin
      check("early_vld", out_vld, 0);
      step();
    end
    check("lat_vld", out_vld, 1);
    check("lat_data", out_data, e);
    check("lat_idx", out_idx, idx);
    check("lat_last", out_last, 0);
    step();
    check("popped_vld", out_vld, 0);
  endtask

  task automatic drain(input int first, input int n);
    int k = 0;
    out_rdy = 1'b1;
    for (int c = 0; c < 20; c++) begin
      if (out_vld) begin
        check("drain_data", out_data, (first + k) << 8);
        check("drain_idx", out_idx, first + k);
        k++;
      end
      step();
    end
    check("drain_count", k, n);
    check("drain_level", fifo_level, 0);
    check("drain_vld", out_vld, 0);
  endtask

  task automatic run_stream();
    got_data.delete(); got_idx.delete(); got_last.delete();
    out_rdy = 1'b1;
    for (int c = 0; c < st_vld.size() + 8; c++) begin
      if (out_vld) begin
        got_data.push_back(int'(out_data));
        got_idx.push_back(int'(out_idx));
        got_last.push_back(int'(out_last));
      end
      mel_spec_vld = (c < st_vld.size()) ? st_vld[c] : 1'b0;
      frame_rst    = (c < st_vld.size()) ? st_frst[c] : 1'b0;
      mel_spec     = (c < st_vld.size()) ? st_data[c] : 16'h0;
      step();
    end
    mel_spec_vld = 1'b0; frame_rst = 1'b0;
    check("stream_count", got_idx.size(), exp_idx.size());
    for (int i = 0; i < got_idx.size() && i < exp_idx.size(); i++) begin
      check("stream_data", got_data[i], exp_data[i]);
      check("stream_idx", got_idx[i], exp_idx[i]);
      check("stream_last", got_last[i], (exp_idx[i] == 39) ? 1 : 0);
    end
    check("stream_ovf", overflow, 0);
    st_vld.delete(); st_frst.delete(); st_data.delete(); exp_data.delete(); exp_idx.delete();
  endtask

  logic [15:0] v_in  [5] = '{16'h0001, 16'h8000, 16'h0003, 16'h00C0, 16'h0000};
`ifdef MEL_LOG_LUT_EN
  logic [15:0] v_exp [5] = '{16'h0000, 16'h0F00, 16'h0196, 16'h0796, 16'h0000};
`else
  logic [15:0] v_exp [5] = '{16'h0000, 16'h0F00, 16'h0180, 16'h0780, 16'h0000};
`endif

  initial begin
    step(); step(); step();
    check("rst_vld", out_vld, 0);
    check("rst_data", out_data, 0);
    check("rst_idx", out_idx, 0);
    check("rst_last", out_last, 0);
    check("rst_ovf", overflow, 0);
    check("rst_level", fifo_level, 0);
    rst = 1'b0;
    step();

    for (int i = 0; i < 5; i++) single(v_in[i], v_exp[i], i);

    // two full frames back to back
    st_vld.push_back(1'b0); st_frst.push_back(1'b1); st_data.push_back(16'h0);
    for (int i = 0; i < 80; i++) begin
      st_vld.push_back(1'b1); st_frst.push_back(1'b0); st_data.push_back(16'h1 << (i % 16));
      exp_data.push_back((i % 16) << 8); exp_idx.push_back(i % 40);
    end
    run_stream();

    // overflow with stalled consumer
    out_rdy = 1'b0;
    for (int i = 0; i < 12; i++) begin
      frame_rst = (i == 0); mel_spec = 16'h1 << i; mel_spec_vld = 1'b1;
      step();
    end
    frame_rst = 1'b0; mel_spec_vld = 1'b0;
    for (int i = 0; i < 5; i++) step();
    check("full_level", fifo_level, 8);
    check("full_ovf", overflow, 1);
    check("full_head_idx", out_idx, 0);
    check("full_head_data", out_data, 0);
    clear_ovf = 1'b1; step(); clear_ovf = 1'b0;
    check("clr_ovf", overflow, 0);
    drain(0, 8);

    // write on full with a same-cycle pop
    out_rdy = 1'b0;
    for (int i = 0; i < 8; i++) begin
      frame_rst = (i == 0); mel_spec = 16'h1 << i; mel_spec_vld = 1'b1;
      step();
    end
    frame_rst = 1'b0; mel_spec_vld = 1'b0;
    for (int i = 0; i < 5; i++) step();
    check("pre_level", fifo_level, 8);
    mel_spec = 16'h0100; mel_spec_vld = 1'b1; step();
    mel_spec_vld = 1'b0; step(); step();
    out_rdy = 1'b1; step(); out_rdy = 1'b0;
    check("fullpop_level", fifo_level, 8);
    check("fullpop_ovf", overflow, 0);
    check("fullpop_head", out_idx, 1);
    check("fullpop_data", out_data, 16'h0100);
    drain(1, 8);

    // frame_rst coincident with the sixth strobe
    st_vld.push_back(1'b0); st_frst.push_back(1'b1); st_data.push_back(16'h0);
    for (int i = 0; i < 7; i++) begin
      st_vld.push_back(1'b1); st_frst.push_back(i == 5); st_data.push_back(16'h1 << i);
      exp_data.push_back(i << 8); exp_idx.push_back((i < 5) ? i : i - 5);
    end
    run_stream();

    // reset in the middle of an overflowing burst
    out_rdy = 1'b0;
    for (int i = 0; i < 14; i++) begin
      if (i == 13) check("pre_rst_ovf", overflow, 1);
      frame_rst = (i == 0); rst = (i == 13); mel_spec = 16'h1 << i; mel_spec_vld = 1'b1;
      step();
    end
    rst = 1'b0; frame_rst = 1'b0; mel_spec_vld = 1'b0;
    check("mrst_vld", out_vld, 0);
    check("mrst_ovf", overflow, 0);
    check("mrst_level", fifo_level, 0);
    for (int i = 0; i < 5; i++) step();
    check("mrst_flushed", out_vld, 0);
    single(16'h0003, v_exp[2], 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
